core_dispatcher: RTL and testbench

Host-side launch controller for the videocard compute cores. Accepts one launch command at a time, holding a core mask and a start address. Enables and starts the selected cores, then tracks their per-core done lines until every enabled core has finished, a watchdog expires, or the host aborts. It is the issuing end of the core start/done protocol; the completion-collection interrupt logic sits downstream on the same done lines.

---
 rtl/dispatcher_pkg.sv | 15 +
 rtl/dispatch_watchdog.sv | 31 +++
 rtl/core_dispatcher.sv | 106 ++++++++++
 tb/tb_core_dispatcher.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared types and status codes for the compute-core launch dispatcher.
package dispatcher_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FINISH
    } disp_state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

endpackage

// File: rtl/dispatch_watchdog.sv
// Saturating RUN-cycle counter; expired flags the TIMEOUT-th enabled cycle.
module dispatch_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != SAT) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of completed RUN cycles, so LAST marks the TIMEOUT-th one
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/core_dispatcher.sv
// Launch controller: starts the selected compute cores and collects their done lines.
module core_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                launch_valid,
    output logic                launch_ready,
    input  logic [CORE_NUM-1:0] launch_mask,
    input  logic [ADDR_W-1:0]   launch_addr,
    input  logic                abort,
    output logic [CORE_NUM-1:0] core_en,
    output logic [CORE_NUM-1:0] core_start,
    output logic [ADDR_W-1:0]   core_addr,
    input  logic [CORE_NUM-1:0] core_done,
    output logic                busy,
    output logic                launch_done,
    output logic [1:0]          status,
    output logic [CORE_NUM-1:0] done_mask
);

    disp_state_t         state;
    logic [CORE_NUM-1:0] done_now;
    logic [CORE_NUM-1:0] done_all;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    assign done_now     = core_done & core_en;
    assign done_all     = done_mask | done_now;
    assign launch_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign wd_clear     = (state == S_START);
    assign wd_enable    = (state == S_RUN);

    dispatch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            core_en     <= '0;
            core_start  <= '0;
            core_addr   <= '0;
            launch_done <= 1'b0;
            status      <= ST_OK;
            done_mask   <= '0;
        end else begin
            core_start  <= '0;
            launch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch_valid) begin
                        core_en    <= launch_mask;
                        core_addr  <= launch_addr;
                        core_start <= launch_mask;
                        done_mask  <= '0;
                        status     <= ST_OK;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (core_en == '0) begin
                        launch_done <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    done_mask <= done_all;
                    // completion wins over abort, abort wins over the watchdog
                    if (done_all == core_en) begin
                        launch_done <= 1'b1;
                        state       <= S_FINISH;
                    end else if (abort) begin
                        status      <= ST_ABORT;
                        launch_done <= 1'b1;
                        state       <= S_FINISH;
                    end else if (wd_expired) begin
                        status      <= ST_TIMEOUT;
                        launch_done <= 1'b1;
                        state       <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    core_en <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_dispatcher.sv
// Randomized and directed bench for core_dispatcher against a launch-level model.
module tb_core_dispatcher;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          launch_valid;
    logic          launch_ready;
    logic [N-1:0]  launch_mask;
    logic [AW-1:0] launch_addr;
    logic          abort;
    logic [N-1:0]  core_en;
    logic [N-1:0]  core_start;
    logic [AW-1:0] core_addr;
    logic [N-1:0]  core_done;
    logic          busy;
    logic          launch_done;
    logic [1:0]    status;
    logic [N-1:0]  done_mask;

    int vectors     = 0;
    int miscompares = 0;
    int due [N];

    always #5 clk = ~clk;

    core_dispatcher #(
        .CORE_NUM (N),
        .ADDR_W   (AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch_valid (launch_valid),
        .launch_ready (launch_ready),
        .launch_mask  (launch_mask),
        .launch_addr  (launch_addr),
        .abort        (abort),
        .core_en      (core_en),
        .core_start   (core_start),
        .core_addr    (core_addr),
        .core_done    (core_done),
        .busy         (busy),
        .launch_done  (launch_done),
        .status       (status),
        .done_mask    (done_mask)
    );

    // Cores of mask that have reported by RUN cycle k (due[i] is the RUN cycle of core i's pulse, 0 = never).
    function automatic logic [N-1:0] done_by(input logic [N-1:0] mask, input int k);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (mask[i] && due[i] >= 1 && due[i] <= k) r[i] = 1'b1;
        return r;
    endfunction

    // Outcome of a launch: RUN cycle in which it ends (0 = ends from START) and its status.
    function automatic void model(input logic [N-1:0] mask, input int ab,
                                  output int kend, output logic [1:0] st);
        kend = 0;
        st   = 2'b00;
        if (mask != '0) begin
            for (int k = 1; k <= TO; k++) begin
                if (done_by(mask, k) == mask) begin kend = k; st = 2'b00; break; end
                if (ab == k)                  begin kend = k; st = 2'b10; break; end
                if (k == TO)                  begin kend = k; st = 2'b01; break; end
            end
        end
    endfunction

    task automatic run_launch(input logic [N-1:0] mask, input logic [AW-1:0] addr, input int ab,
                              input logic [N-1:0] dis_lvl, input bit rnd, input string tag);
        int           kend;
        int           waited;
        logic [1:0]   st_exp;
        logic [N-1:0] pulse;
        logic [N-1:0] noise;
        model(mask, ab, kend, st_exp);
        waited = 0;
        while (launch_ready !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
        vectors++; if (launch_ready !== 1'b1) begin miscompares++; $display("FAIL %s ready_wait: got %b want 1", tag, launch_ready); end
        launch_valid = 1'b1; launch_mask = mask; launch_addr = addr;
        @(posedge clk); #1;
        vectors++; if (core_start !== mask) begin miscompares++; $display("FAIL %s start_pulse: got %b want %b", tag, core_start, mask); end
        vectors++; if (core_en !== mask) begin miscompares++; $display("FAIL %s start_en: got %b want %b", tag, core_en, mask); end
        vectors++; if (core_addr !== addr) begin miscompares++; $display("FAIL %s start_addr: got %h want %h", tag, core_addr, addr); end
        vectors++; if ({busy, launch_ready} !== 2'b10) begin miscompares++; $display("FAIL %s start_busy_ready: got %b want 10", tag, {busy, launch_ready}); end
        for (int k = 0; k <= kend; k++) begin
            noise = rnd ? N'($urandom) : dis_lvl;
            pulse = '0;
            for (int i = 0; i < N; i++) if (mask[i] && due[i] == k && k > 0) pulse[i] = 1'b1;
            core_done    = (k == 0) ? noise : ((noise & ~mask) | pulse);
            abort        = (ab > 0 && k == ab) || (k == 0 && rnd && $urandom_range(0, 1) == 1);
            launch_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
            launch_mask  = N'($urandom);
            launch_addr  = AW'($urandom);
            @(posedge clk); #1;
            vectors++; if (launch_done !== (k == kend)) begin miscompares++; $display("FAIL %s launch_done k=%0d: got %b want %b", tag, k, launch_done, (k == kend)); end
            vectors++; if (core_start !== '0) begin miscompares++; $display("FAIL %s start_len k=%0d: got %b want 0", tag, k, core_start); end
            vectors++; if (core_en !== mask) begin miscompares++; $display("FAIL %s en_hold k=%0d: got %b want %b", tag, k, core_en, mask); end
            vectors++; if (done_mask !== done_by(mask, k)) begin miscompares++; $display("FAIL %s done_mask k=%0d: got %b want %b", tag, k, done_mask, done_by(mask, k)); end
            vectors++; if (status !== ((k == kend) ? st_exp : 2'b00)) begin miscompares++; $display("FAIL %s status k=%0d: got %b want %b", tag, k, status, ((k == kend) ? st_exp : 2'b00)); end
        end
        core_done = N'($urandom); abort = $urandom_range(0, 1) == 1;
        @(posedge clk); #1;
        launch_valid = 1'b0; core_done = '0; abort = 1'b0;
        vectors++; if ({launch_ready, busy, launch_done} !== 3'b100) begin miscompares++; $display("FAIL %s idle_flags: got %b want 100", tag, {launch_ready, busy, launch_done}); end
        vectors++; if (core_en !== '0) begin miscompares++; $display("FAIL %s idle_en: got %b want 0", tag, core_en); end
        vectors++; if (core_addr !== addr) begin miscompares++; $display("FAIL %s idle_addr: got %h want %h", tag, core_addr, addr); end
        vectors++; if (status !== st_exp) begin miscompares++; $display("FAIL %s idle_status: got %b want %b", tag, status, st_exp); end
        vectors++; if (done_mask !== done_by(mask, kend)) begin miscompares++; $display("FAIL %s idle_done_mask: got %b want %b", tag, done_mask, done_by(mask, kend)); end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++; if ({launch_ready, busy, launch_done} !== 3'b100) begin miscompares++; $display("FAIL %s flags: got %b want 100", tag, {launch_ready, busy, launch_done}); end
        vectors++; if ({core_en, core_start} !== '0) begin miscompares++; $display("FAIL %s en_start: got %b want 0", tag, {core_en, core_start}); end
        vectors++; if (core_addr !== '0) begin miscompares++; $display("FAIL %s addr: got %h want 0", tag, core_addr); end
        vectors++; if ({status, done_mask} !== '0) begin miscompares++; $display("FAIL %s status_mask: got %b want 0", tag, {status, done_mask}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; launch_valid = 1'b0; launch_mask = '0; launch_addr = '0; abort = 1'b0; core_done = '0;
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset_release");
    endtask

    task automatic test_all_cores();
        due = '{1, 3, 2, 5};
        run_launch(4'b1111, 16'h0100, 0, 4'b0000, 1'b0, "all_cores");
    endtask

    task automatic test_disabled_lines();
        due = '{2, 1, 4, 1};
        run_launch(4'b0101, 16'h2222, 0, 4'b1010, 1'b0, "disabled_lines");
    endtask

    task automatic test_zero_mask();
        due = '{1, 1, 1, 1};
        run_launch(4'b0000, 16'h3333, 0, 4'b0000, 1'b0, "zero_mask");
    endtask

    task automatic test_timeout();
        due = '{1, 0, 0, 0};
        run_launch(4'b0011, 16'h4444, 0, 4'b0000, 1'b0, "timeout");
    endtask

    task automatic test_abort();
        due = '{1, 2, 3, 3};
        run_launch(4'b1111, 16'h5555, 3, 4'b0000, 1'b0, "abort_with_done");
        due = '{1, 0, 0, 0};
        run_launch(4'b1111, 16'h6666, 2, 4'b0000, 1'b0, "abort_alone");
    endtask

    task automatic test_reset_mid_run();
        launch_valid = 1'b1; launch_mask = 4'b1111; launch_addr = 16'hBEEF;
        @(posedge clk); #1;
        launch_valid = 1'b0; core_done = '0;
        @(posedge clk); #1;
        core_done = 4'b0001;
        @(posedge clk); #1;
        core_done = '0;
        vectors++; if (done_mask !== 4'b0001) begin miscompares++; $display("FAIL mid_run_progress: got %b want 0001", done_mask); end
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_run");
        @(posedge clk); #1;
        check_reset_values("reset_mid_run_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        due = '{2, 2, 1, 3};
        run_launch(4'b1111, 16'h7777, 0, 4'b0000, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        due = '{1, 1, 1, 1};
        run_launch(4'b1111, 16'h8888, 0, 4'b0000, 1'b0, "b2b_first");
        due = '{0, 1, 0, 0};
        run_launch(4'b0010, 16'h9999, 0, 4'b0000, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int           ab;
        for (int n = 0; n < 40; n++) begin
            mask = N'($urandom);
            for (int i = 0; i < N; i++) due[i] = $urandom_range(0, 9);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
            run_launch(mask, AW'($urandom), ab, 4'b0000, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_all_cores();
        test_disabled_lines();
        test_zero_mask();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
